// File: rtl/bru_pkg.sv
// Shared types for the branch resolution unit: in-flight prediction record,
// resolution FSM states and the prediction-check helper.
package bru_pkg;

    localparam int unsigned PC_W = 64;

    // One fetch-time prediction; pred == 0 means "predicted not-taken".
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred;
    } inflight_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_t;

    // A prediction is right when a taken outcome hit the recorded target,
    // or a not-taken outcome was recorded with no target at all.
    function automatic logic pred_correct(input inflight_entry_t e,
                                          input logic            taken,
                                          input logic [PC_W-1:0] target);
        if (taken) begin
            return e.pred == target;
        end
        return e.pred == '0;
    endfunction

endpackage

// File: rtl/bru_inflight_fifo.sv
// In-flight prediction FIFO: one entry per fetched instruction awaiting
// resolution. Clear has priority over push and pop.
module bru_inflight_fifo
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   push,
    input  inflight_entry_t        push_entry,
    input  logic                   pop,
    input  logic                   clear,
    output inflight_entry_t        head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    inflight_entry_t mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [OccW-1:0] occ_q;
    logic            do_push, do_pop;

    assign full      = occ_q == OccW'(DEPTH);
    assign empty     = occ_q == '0;
    assign occupancy = occ_q;
    assign head      = mem_q[rd_ptr_q];

    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    // Entry storage; contents behind the pointers need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!arst_n || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            occ_q <= occ_q + OccW'(do_push) - OccW'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: checks fetch-time BTB predictions against execute
// outcomes, raises redirect/flush on a mispredict and emits BTB updates.
// Optional macro BRU_PERF_COUNTERS_EN adds resolve/mispredict counters.
module branch_resolution_unit
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned INSTR_BYTES  = 4
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   push_valid,
    input  logic [63:0]            push_pc,
    input  logic [63:0]            push_pred,
    output logic                   push_full,
    input  logic                   res_valid,
    input  logic [63:0]            res_pc,
    input  logic                   res_taken,
    input  logic                   res_jumped,
    input  logic [63:0]            res_target,
    output logic                   mispredict,
    output logic [63:0]            redirect_pc,
    output logic                   flush,
    output logic                   upd_valid,
    output logic [63:0]            upd_pc,
    output logic [63:0]            upd_target,
    output logic                   upd_taken,
    output logic                   upd_jumped,
    output logic                   sync_error,
`ifdef BRU_PERF_COUNTERS_EN
    output logic [31:0]            perf_resolved,
    output logic [31:0]            perf_mispredicts,
`endif
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);

    bru_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    inflight_entry_t head;
    inflight_entry_t push_entry;
    logic            fifo_full, fifo_empty;
    logic            in_run, res_accept, push_accept, taken, pc_mismatch, miss;
    logic [63:0]     redirect_next;

    assign push_entry = '{pc: push_pc, pred: push_pred};
    assign push_full  = fifo_full;

    // Resolve decision against the head entry as held at the start of the cycle.
    always_comb begin
        in_run        = state_q == RUN;
        taken         = res_taken | res_jumped;
        res_accept    = res_valid & ~fifo_empty & in_run;
        pc_mismatch   = head.pc != res_pc;
        miss          = res_accept & (pc_mismatch | ~pred_correct(head, taken, res_target));
        // A push racing a mispredict belongs to the squashed path.
        push_accept   = push_valid & ~fifo_full & in_run & ~miss;
        redirect_next = taken ? res_target : res_pc + 64'(INSTR_BYTES);
    end

    bru_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .arst_n     (arst_n),
        .push       (push_accept),
        .push_entry (push_entry),
        .pop        (res_accept),
        .clear      (miss),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .occupancy  (occupancy)
    );

    // RUN/FLUSH sequencing; the counter holds how many flush cycles have elapsed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (miss) begin
                    state_d = FLUSH;
                    cnt_d   = CntW'(1);
                end
            end
            FLUSH: begin
                if (cnt_q == CntW'(FLUSH_CYCLES)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs; data fields are zero whenever their strobe is low.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            flush       <= 1'b0;
            sync_error  <= 1'b0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_target  <= '0;
            upd_taken   <= 1'b0;
            upd_jumped  <= 1'b0;
        end else begin
            mispredict  <= miss;
            redirect_pc <= miss ? redirect_next : '0;
            flush       <= state_d == FLUSH;
            sync_error  <= res_accept & pc_mismatch;
            upd_valid   <= res_accept & taken;
            upd_pc      <= (res_accept & taken) ? res_pc : '0;
            upd_target  <= (res_accept & taken) ? res_target : '0;
            upd_taken   <= res_accept & taken & res_taken;
            upd_jumped  <= res_accept & taken & res_jumped;
        end
    end

`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] perf_resolved_q, perf_mispredicts_q;

    assign perf_resolved    = perf_resolved_q;
    assign perf_mispredicts = perf_mispredicts_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            perf_resolved_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            perf_resolved_q    <= perf_resolved_q + 32'(res_accept);
            perf_mispredicts_q <= perf_mispredicts_q + 32'(miss);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed vector table with
// explicit expectations, then randomized traffic against a queue-based model.
module tb_branch_resolution_unit;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned INSTR_BYTES  = 4;

    logic        clk;
    logic        arst_n;
    logic        push_valid;
    logic [63:0] push_pc, push_pred;
    logic        push_full;
    logic        res_valid;
    logic [63:0] res_pc;
    logic        res_taken, res_jumped;
    logic [63:0] res_target;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic        flush, upd_valid;
    logic [63:0] upd_pc, upd_target;
    logic        upd_taken, upd_jumped, sync_error;
    logic [2:0]  occupancy;
`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] perf_resolved, perf_mispredicts;
`endif

    branch_resolution_unit #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .INSTR_BYTES  (INSTR_BYTES)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred        (push_pred),
        .push_full        (push_full),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_jumped       (res_jumped),
        .res_target       (res_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .upd_jumped       (upd_jumped),
        .sync_error       (sync_error),
`ifdef BRU_PERF_COUNTERS_EN
        .perf_resolved    (perf_resolved),
        .perf_mispredicts (perf_mispredicts),
`endif
        .occupancy        (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [63:0] pred;
    } rec_t;

    rec_t        mq[$];
    int          flush_left = 0;
    logic        m_mis, m_se, m_uv, m_ut, m_uj, m_fl;
    logic [63:0] m_redir, m_upc, m_utgt;
    int          m_occ;
    logic [31:0] m_pres = 0, m_pmis = 0;

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic taken, accept, miss, push_ok;
        rec_t h, r;
        m_mis = 0; m_se = 0; m_uv = 0; m_ut = 0; m_uj = 0;
        m_redir = 0; m_upc = 0; m_utgt = 0;
        if (!arst_n) begin
            mq.delete();
            flush_left = 0;
            m_pres = 0;
            m_pmis = 0;
        end else begin
            taken   = res_taken || res_jumped;
            accept  = res_valid && mq.size() > 0 && flush_left == 0;
            push_ok = push_valid && mq.size() < DEPTH && flush_left == 0;
            miss    = 0;
            if (flush_left > 0) flush_left--;
            if (accept) begin
                h    = mq.pop_front();
                m_se = h.pc != res_pc;
                miss = m_se || (taken ? h.pred != res_target : h.pred != 0);
                m_pres++;
                if (taken) begin
                    m_uv = 1; m_upc = res_pc; m_utgt = res_target;
                    m_ut = res_taken; m_uj = res_jumped;
                end
            end
            if (miss) begin
                mq.delete();
                flush_left = FLUSH_CYCLES;
                m_mis   = 1;
                m_redir = taken ? res_target : res_pc + INSTR_BYTES;
                m_pmis++;
            end else if (push_ok) begin
                r.pc = push_pc;
                r.pred = push_pred;
                mq.push_back(r);
            end
        end
        m_fl  = flush_left > 0;
        m_occ = mq.size();
    endtask

    // ---------------- Directed vector table ----------------
    typedef struct {
        logic        rst_n, pv;
        logic [63:0] ppc, ppred;
        logic        rv;
        logic [63:0] rpc;
        logic        rt, rj;
        logic [63:0] rtgt;
        logic        emis;
        logic [63:0] eredir;
        logic        efl, euv;
        logic [63:0] eupc, eutgt;
        logic        eut, euj, ese;
        int          eocc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t vidle(input logic efl, input int eocc);
        vec_t v = '{default: 0};
        v.rst_n = 1;
        v.efl   = efl;
        v.eocc  = eocc;
        return v;
    endfunction

    function automatic vec_t vrst();
        vec_t v = vidle(0, 0);
        v.rst_n = 0;
        return v;
    endfunction

    function automatic vec_t vpush(input logic [63:0] pc, input logic [63:0] pred, input int eocc);
        vec_t v = vidle(0, eocc);
        v.pv = 1; v.ppc = pc; v.ppred = pred;
        return v;
    endfunction

    function automatic vec_t vres(input logic [63:0] pc, input logic t, input logic j,
                                  input logic [63:0] tgt, input int eocc);
        vec_t v = vidle(0, eocc);
        v.rv = 1; v.rpc = pc; v.rt = t; v.rj = j; v.rtgt = tgt;
        return v;
    endfunction

    // Expected BTB write-back mirrors the resolve inputs.
    function automatic vec_t vupd(input vec_t vi);
        vec_t v = vi;
        v.euv = 1; v.eupc = v.rpc; v.eutgt = v.rtgt; v.eut = v.rt; v.euj = v.rj;
        return v;
    endfunction

    function automatic vec_t vmis(input vec_t vi, input logic [63:0] redir);
        vec_t v = vi;
        v.emis = 1; v.eredir = redir; v.efl = 1;
        return v;
    endfunction

    task automatic build_table();
        vec_t v;
        tv.push_back(vrst());
        // Correct taken prediction.
        tv.push_back(vpush(64'h100, 64'h200, 1));
        tv.push_back(vupd(vres(64'h100, 1, 0, 64'h200, 0)));
        // Correct jump prediction.
        tv.push_back(vpush(64'h600, 64'h700, 1));
        tv.push_back(vupd(vres(64'h600, 0, 1, 64'h700, 0)));
        // Predicted not-taken, actually taken; same-cycle push discarded.
        tv.push_back(vpush(64'h100, 64'h0, 1));
        v = vmis(vupd(vres(64'h100, 1, 0, 64'h180, 0)), 64'h180);
        v.pv = 1; v.ppc = 64'h184;
        tv.push_back(v);
        tv.push_back(vidle(1, 0));
        tv.push_back(vidle(0, 0));
        // Predicted taken, actually not-taken: fall-through redirect, no update.
        tv.push_back(vpush(64'h104, 64'h300, 1));
        tv.push_back(vmis(vres(64'h104, 0, 0, 64'h0, 0), 64'h108));
        tv.push_back(vidle(1, 0));
        tv.push_back(vidle(0, 0));
        // Fill to full, overflow push dropped, full push+pop rejected.
        tv.push_back(vpush(64'h10, 64'h0, 1));
        tv.push_back(vpush(64'h14, 64'h0, 2));
        tv.push_back(vpush(64'h18, 64'h0, 3));
        tv.push_back(vpush(64'h1c, 64'h0, 4));
        tv.push_back(vpush(64'h20, 64'h0, 4));
        v = vres(64'h10, 0, 0, 64'h0, 3);
        v.pv = 1; v.ppc = 64'h20;
        tv.push_back(v);
        tv.push_back(vpush(64'h20, 64'h0, 4));
        tv.push_back(vres(64'h14, 0, 0, 64'h0, 3));
        // Non-full push + correct resolve: occupancy unchanged.
        v = vres(64'h18, 0, 0, 64'h0, 3);
        v.pv = 1; v.ppc = 64'h24;
        tv.push_back(v);
        tv.push_back(vres(64'h1c, 0, 0, 64'h0, 2));
        tv.push_back(vres(64'h20, 0, 0, 64'h0, 1));
        tv.push_back(vres(64'h24, 0, 0, 64'h0, 0));
        // PC mismatch, then push/resolve during flush ignored.
        tv.push_back(vpush(64'h100, 64'h0, 1));
        v = vmis(vres(64'h140, 0, 0, 64'h0, 0), 64'h144);
        v.ese = 1;
        tv.push_back(v);
        v = vidle(1, 0);
        v.pv = 1; v.ppc = 64'h200; v.rv = 1; v.rpc = 64'h200;
        tv.push_back(v);
        v = vidle(0, 0);
        v.pv = 1; v.ppc = 64'h204;
        tv.push_back(v);
        tv.push_back(vidle(0, 0));
        // Reset during the flush aborts it.
        tv.push_back(vpush(64'h300, 64'h0, 1));
        tv.push_back(vmis(vupd(vres(64'h300, 1, 0, 64'h400, 0)), 64'h400));
        tv.push_back(vrst());
        tv.push_back(vidle(0, 0));
        // Fall-through redirect wraps past the top of the address space.
        tv.push_back(vpush(64'hFFFF_FFFF_FFFF_FFFC, 64'h500, 1));
        tv.push_back(vmis(vres(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0, 0), 64'h0));
        tv.push_back(vidle(1, 0));
        tv.push_back(vidle(0, 0));
    endtask

    task automatic drive(input vec_t v);
        arst_n = v.rst_n; push_valid = v.pv; push_pc = v.ppc; push_pred = v.ppred;
        res_valid = v.rv; res_pc = v.rpc; res_taken = v.rt; res_jumped = v.rj;
        res_target = v.rtgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic check_model(input int c);
        string p = $sformatf("rnd%0d", c);
        chk({p, " mispredict"}, 64'(mispredict), 64'(m_mis));
        chk({p, " sync_error"}, 64'(sync_error), 64'(m_se));
        chk({p, " flush"}, 64'(flush), 64'(m_fl));
        chk({p, " upd_valid"}, 64'(upd_valid), 64'(m_uv));
        chk({p, " occupancy"}, 64'(occupancy), 64'(m_occ));
        chk({p, " push_full"}, 64'(push_full), 64'(m_occ == DEPTH));
        if (m_mis) chk({p, " redirect_pc"}, redirect_pc, m_redir);
        if (m_uv) begin
            chk({p, " upd_pc"}, upd_pc, m_upc);
            chk({p, " upd_target"}, upd_target, m_utgt);
            chk({p, " upd_taken"}, 64'(upd_taken), 64'(m_ut));
            chk({p, " upd_jumped"}, 64'(upd_jumped), 64'(m_uj));
        end
`ifdef BRU_PERF_COUNTERS_EN
        chk({p, " perf_resolved"}, 64'(perf_resolved), 64'(m_pres));
        chk({p, " perf_mispredicts"}, 64'(perf_mispredicts), 64'(m_pmis));
`endif
    endtask

    initial begin
        vec_t v;
        drive(vrst());
        build_table();

        for (int i = 0; i < tv.size(); i++) begin
            string p;
            v = tv[i];
            p = $sformatf("vec%0d", i);
            drive(v);
            tick();
            chk({p, " mispredict"}, 64'(mispredict), 64'(v.emis));
            chk({p, " sync_error"}, 64'(sync_error), 64'(v.ese));
            chk({p, " flush"}, 64'(flush), 64'(v.efl));
            chk({p, " upd_valid"}, 64'(upd_valid), 64'(v.euv));
            chk({p, " occupancy"}, 64'(occupancy), 64'(v.eocc));
            chk({p, " push_full"}, 64'(push_full), 64'(v.eocc == DEPTH));
            if (v.emis) chk({p, " redirect_pc"}, redirect_pc, v.eredir);
            if (v.euv) begin
                chk({p, " upd_pc"}, upd_pc, v.eupc);
                chk({p, " upd_target"}, upd_target, v.eutgt);
                chk({p, " upd_taken"}, 64'(upd_taken), 64'(v.eut));
                chk({p, " upd_jumped"}, 64'(upd_jumped), 64'(v.euj));
            end
        end

        // Randomized traffic, biased towards correct predictions so the FIFO fills.
        for (int c = 0; c < 3000; c++) begin
            arst_n     = $urandom_range(0, 199) != 0;
            push_valid = $urandom_range(0, 1) == 1;
            push_pc    = 64'h1000 + 64'($urandom_range(0, 15)) * 4;
            push_pred  = ($urandom_range(0, 1) == 1) ? 64'h0
                                                     : 64'h2000 + 64'($urandom_range(0, 3)) * 4;
            res_valid  = $urandom_range(0, 2) != 0;
            res_pc     = 64'h1000 + 64'($urandom_range(0, 15)) * 4;
            res_taken  = $urandom_range(0, 1) == 1;
            res_jumped = $urandom_range(0, 3) == 0;
            res_target = 64'h2000 + 64'($urandom_range(0, 3)) * 4;
            if (mq.size() > 0 && $urandom_range(0, 9) != 0) res_pc = mq[0].pc;
            if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
                res_target = mq[0].pred;
                res_jumped = 0;
                res_taken  = mq[0].pred != 0;
            end
            tick();
            check_model(c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
